// File: rtl/i2s_tx_pkg.sv
// Shared constants and helper functions for the I2S transmit path.
package i2s_tx_pkg;

    // The MSB goes out one bit period after the word-select edge.
    localparam int unsigned I2S_DELAY = 1;

    function automatic int unsigned slot_count(input int unsigned data_width);
        return 2 * data_width;
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with occupancy level; a pop frees a slot for a same-cycle push.
module sample_fifo
    import i2s_tx_pkg::*;
#(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [width-1:0]                push_data,
    input  logic                            pop,
    output logic [width-1:0]                pop_data,
    output logic                            full,
    output logic                            empty,
    output logic [level_width(depth)-1:0]   level
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned LW = level_width(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        full     = (level == LW'(depth));
        empty    = (level == '0);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        pop_data = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S stereo serialiser: buffers mixer samples and sends each one on both slots.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int unsigned data_width = 16,
    parameter int unsigned bclk_div   = 8,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [data_width-1:0]                sample_in,
    input  logic                                 sample_in_valid,
    output logic                                 bclk,
    output logic                                 lrclk,
    output logic                                 sdata,
    output logic                                 frame_start,
    output logic [level_width(fifo_depth)-1:0]   fifo_level,
    output logic                                 underflow,
    output logic                                 overflow
);

    localparam int unsigned SLOTS = slot_count(data_width);
    localparam int unsigned SW    = $clog2(SLOTS);
    localparam int unsigned DIVW  = $clog2(bclk_div);

    logic [DIVW-1:0]       div_cnt;
    logic [SW-1:0]         slot;
    logic [SW-1:0]         slot_nxt;
    logic [data_width-1:0] shreg;
    logic [data_width-1:0] frame_word;
    logic [data_width-1:0] fifo_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  div_wrap;
    logic                  fall_evt;
    logic                  frame_pop;
    logic                  load;

    always_comb begin
        div_wrap  = (div_cnt == DIVW'(bclk_div - 1));
        fall_evt  = div_wrap && bclk;
        slot_nxt  = (slot == SW'(SLOTS - 1)) ? '0 : slot + 1'b1;
        frame_pop = fall_evt && (slot_nxt == '0);
        load      = (slot_nxt == SW'(I2S_DELAY)) ||
                    (slot_nxt == SW'(data_width + I2S_DELAY));
    end

    sample_fifo #(
        .width (data_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (sample_in_valid),
        .push_data (sample_in),
        .pop       (frame_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            slot        <= SW'(SLOTS - 1);
            shreg       <= '0;
            frame_word  <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_start <= frame_pop;

            if (div_wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fall_evt) begin
                slot  <= slot_nxt;
                lrclk <= (slot_nxt >= SW'(data_width));
                // A load slot sends the new word's MSB straight away and keeps the rest queued.
                if (load) begin
                    sdata <= frame_word[data_width-1];
                    shreg <= {frame_word[data_width-2:0], 1'b0};
                end else begin
                    sdata <= shreg[data_width-1];
                    shreg <= {shreg[data_width-2:0], 1'b0};
                end
            end

            if (frame_pop) begin
                frame_word <= fifo_empty ? '0 : fifo_data;
                if (fifo_empty) underflow <= 1'b1;
            end

            if (sample_in_valid && fifo_full && !frame_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with a sample scoreboard and cycle-based frame monitor.
module tb_i2s_tx;
    import i2s_tx_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned DIV   = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = level_width(DEPTH);
    localparam int          BITP  = 2 * DIV;
    localparam int          FIRST = 2 * DIV;
    localparam int          FRAME = 2 * DW * 2 * DIV;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_in_valid = 1'b0;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          frame_start;
    logic [LW-1:0] fifo_level;
    logic          underflow;
    logic          overflow;

    i2s_tx #(
        .data_width (DW),
        .bclk_div   (DIV),
        .fifo_depth (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .sdata           (sdata),
        .frame_start     (frame_start),
        .fifo_level      (fifo_level),
        .underflow       (underflow),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int          n_checks = 0;
    int          n_pass = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    bit          m_uf = 1'b0;
    bit          m_of = 1'b0;
    int          frames_checked = 0;
    logic [31:0] sh = '0;
    int          nb = 0;
    int          slot;
    int          en;
    logic [DW-1:0] exp_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                chk("wait_timeout", 32'(cyc), 32'(n));
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $fatal(1, "FAIL wait_timeout");
            end
        end
    endtask

    task automatic push_at(input int n, input logic [DW-1:0] d);
        wait_cyc(n - 1);
        sample_in       = d;
        sample_in_valid = 1'b1;
        @(negedge clk);
        sample_in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_bclk"},        bclk,        0);
        chk({pfx, "_lrclk"},       lrclk,       0);
        chk({pfx, "_sdata"},       sdata,       0);
        chk({pfx, "_frame_start"}, frame_start, 0);
        chk({pfx, "_fifo_level"},  fifo_level,  0);
        chk({pfx, "_underflow"},   underflow,   0);
        chk({pfx, "_overflow"},    overflow,    0);
    endtask

    initial begin
        fork
            // Reference FIFO: the slot-0 pop happens before a same-edge push.
            forever begin
                @(posedge clk or negedge reset);
                if (!reset) begin
                    mq.delete();
                    m_uf = 1'b0;
                    m_of = 1'b0;
                end else begin
                    en = cyc + 1;
                    if (en >= FIRST && (en - FIRST) % FRAME == 0) begin
                        if (mq.size() == 0) begin
                            exp_q.push_back('0);
                            m_uf = 1'b1;
                        end else begin
                            exp_q.push_back(mq.pop_front());
                        end
                    end
                    if (sample_in_valid) begin
                        if (mq.size() < DEPTH) mq.push_back(sample_in);
                        else                   m_of = 1'b1;
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (!reset) begin
                    nb = 0;
                end else begin
                    chk("fifo_level",  fifo_level,  32'(mq.size()));
                    chk("underflow",   underflow,   m_uf);
                    chk("overflow",    overflow,    m_of);
                    chk("frame_start", frame_start, (cyc >= FIRST && (cyc - FIRST) % FRAME == 0));
                    if (cyc >= DIV && (cyc - DIV) % BITP == 0) chk("bclk_high", bclk, 1);
                    if (cyc >= FIRST && (cyc - FIRST) % BITP == 0) begin
                        slot = ((cyc - FIRST) / BITP) % (2 * DW);
                        chk("bclk_low", bclk, 0);
                        chk("lrclk", lrclk, (slot >= DW));
                        if (slot == 1) nb = 0;
                        sh = {sh[30:0], sdata};
                        nb++;
                        if (slot == 0) begin
                            if (nb == 2 * DW) begin
                                chk("scoreboard_nonempty", (exp_q.size() != 0), 1);
                                if (exp_q.size() != 0) begin
                                    exp_w = exp_q.pop_front();
                                    chk("left_word",  sh[31:16], exp_w);
                                    chk("right_word", sh[15:0],  exp_w);
                                end
                                frames_checked++;
                            end
                            nb = 0;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        @(negedge clk);
        #1 reset = 1'b1;

        // Single sample before the first frame, then two muted frames.
        push_at(2, 16'h1234);
        wait_cyc(FIRST);
        chk("first_frame_start", frame_start, 1);
        wait_cyc(FIRST + FRAME - 1);
        chk("underflow_before", underflow, 0);
        wait_cyc(FIRST + FRAME);
        chk("underflow_rise", underflow, 1);

        // Fill the FIFO, then push on the pop edge of frame 3.
        for (int i = 0; i < 4; i++) push_at(1100 + i, 16'h0A01 + 16'(i));
        push_at(FIRST + 3 * FRAME, 16'h0A05);
        chk("full_pop_push_level", fifo_level, 4);
        chk("full_pop_push_no_ovf", overflow, 0);

        // Empty FIFO, push on the pop edge of frame 8.
        push_at(FIRST + 8 * FRAME, 16'h0B0B);
        chk("empty_pop_push_level", fifo_level, 1);

        // Five pushes into an empty FIFO: the fifth is dropped.
        for (int i = 1; i <= 5; i++) push_at(4700 + i, 16'(i));
        chk("overflow_level", fifo_level, 4);
        chk("overflow_flag", overflow, 1);

        // Reset in the middle of frame 14's right slot.
        wait_cyc(FIRST + 14 * FRAME + 24 * BITP + 5);
        chk("pre_reset_lrclk", lrclk, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("mid_reset");
        exp_q.delete();
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;

        push_at(2, 16'h1234);
        wait_cyc(FIRST);
        chk("restart_frame_start", frame_start, 1);
        wait_cyc(FIRST + FRAME + 32);
        chk("frames_checked", frames_checked, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
